escape_encoder: RTL and testbench

//  Host-bound VT100 byte generator: turns one reply/key request into the ASCII

---
 rtl/escape_encoder_pkg.sv | 56 +++++
 rtl/escape_encoder_bin2bcd8.sv | 32 +++
 rtl/escape_encoder.sv | 225 ++++++++++++++++++++++
 tb/tb_escape_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/escape_encoder_pkg.sv
// -----------------------------------------------------------------------------
// escape_encoder_pkg
// Shared types and constants for the VT100 host-reply encoder.
//   reply_t     : request kinds accepted on the command port
//   enc_state_t : byte-emission states of the encoder FSM
//   ASCII_*     : fixed bytes used inside the escape sequences
//   sat_add     : 9-bit add of an offset to a byte, saturated to 255
//   ascii_digit : BCD digit -> ASCII '0'..'9'
// -----------------------------------------------------------------------------
package escape_encoder_pkg;

    typedef enum logic [2:0] {
        R_CHAR   = 3'd0,
        R_CPR    = 3'd1,
        R_DSR_OK = 3'd2,
        R_DA     = 3'd3,
        R_KEY    = 3'd4
    } reply_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ESC   = 4'd1,
        S_INTRO = 4'd2,
        S_QMARK = 4'd3,
        S_D1_H  = 4'd4,
        S_D1_T  = 4'd5,
        S_D1_O  = 4'd6,
        S_SEP   = 4'd7,
        S_D2_H  = 4'd8,
        S_D2_T  = 4'd9,
        S_D2_O  = 4'd10,
        S_FINAL = 4'd11,
        S_CHAR  = 4'd12
    } enc_state_t;

    localparam logic [7:0] ASCII_ESC    = 8'h1b;
    localparam logic [7:0] ASCII_LBRACK = 8'h5b;
    localparam logic [7:0] ASCII_O      = 8'h4f;
    localparam logic [7:0] ASCII_SEMI   = 8'h3b;
    localparam logic [7:0] ASCII_QMARK  = 8'h3f;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_R      = 8'h52;
    localparam logic [7:0] ASCII_N      = 8'h6e;
    localparam logic [7:0] ASCII_C      = 8'h63;

    function automatic logic [7:0] sat_add(input logic [7:0] p, input logic [8:0] off);
        logic [8:0] sum;
        sum = {1'b0, p} + off;
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/escape_encoder_bin2bcd8.sv
// -----------------------------------------------------------------------------
// bin2bcd8
// Combinational 8-bit binary to three decimal digits.
//   bin      in  8  value 0..255
//   hundreds out 4  0..2
//   tens     out 4  0..9
//   ones     out 4  0..9
// -----------------------------------------------------------------------------
module bin2bcd8 (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] h8;
    logic [7:0] r8;
    logic [7:0] t8;
    logic [7:0] o8;

    // Constant divisors keep this a small fixed network; all products fit in 8 bits.
    always_comb begin
        h8 = bin / 8'd100;
        r8 = bin - (h8 * 8'd100);
        t8 = r8 / 8'd10;
        o8 = r8 - (t8 * 8'd10);
        hundreds = h8[3:0];
        tens     = t8[3:0];
        ones     = o8[3:0];
    end

endmodule

// File: rtl/escape_encoder.sv
// -----------------------------------------------------------------------------
// escape_encoder
// Turns one reply/key request into the VT100 byte sequence the host expects
// and streams it, one byte per handshake, towards the UART transmitter.
//
// Optional feature macro: ESCENC_DECCKM_EN
//   defined     : app_cursor port exists; R_KEY with latched app_cursor=1
//                 is sent in SS3 form (ESC 'O' key).
//   not defined : no app_cursor port; R_KEY is always ESC '[' key.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   request handshake; cmd_ready high only in IDLE
//   cmd_type          reply_t request kind (unknown codes accepted, no output)
//   cmd_p1, cmd_p2    request parameters (byte/row/key, column)
//   app_cursor        DECCKM state, only with ESCENC_DECCKM_EN
//   tx_data/valid     byte stream to UART
//   tx_ready          UART accepts a byte when tx_valid & tx_ready
//   busy              sequence in progress (= ~cmd_ready)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; while valid is high and ready low, the data is held stable.
// -----------------------------------------------------------------------------
module escape_encoder
    import escape_encoder_pkg::*;
#(
    parameter int POS_OFFSET = 1,
    parameter int DA_ID      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_type,
    input  logic [7:0] cmd_p1,
    input  logic [7:0] cmd_p2,
`ifdef ESCENC_DECCKM_EN
    input  logic       app_cursor,
`endif
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    localparam logic [8:0] OFF9   = POS_OFFSET[8:0];
    localparam logic [7:0] DA_ID8 = (DA_ID > 255) ? 8'hff : DA_ID[7:0];

    enc_state_t state_q, state_d;
    reply_t     type_q, type_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] val1_q, val1_d;
    logic [7:0] val2_q, val2_d;
    logic       key_ss3;
    reply_t     cmd_kind;

    logic [3:0] h1, t1, o1;
    logic [3:0] h2, t2, o2;
    enc_state_t d1_first, d2_first;

`ifdef ESCENC_DECCKM_EN
    logic app_q, app_d;
    assign key_ss3 = app_q && (type_q == R_KEY);
`else
    assign key_ss3 = 1'b0;
`endif

    assign cmd_kind = reply_t'(cmd_type);

    // Digit sources: val1 carries the CPR row, the DSR '0' or the DA id;
    // val2 carries the CPR column. Both are latched already offset/saturated.
    bin2bcd8 u_bcd_p1 (
        .bin      (val1_q),
        .hundreds (h1),
        .tens     (t1),
        .ones     (o1)
    );

    bin2bcd8 u_bcd_p2 (
        .bin      (val2_q),
        .hundreds (h2),
        .tens     (t2),
        .ones     (o2)
    );

    // Leading-zero suppression: jump straight to the first digit that is sent.
    assign d1_first = (h1 != 4'd0) ? S_D1_H : ((t1 != 4'd0) ? S_D1_T : S_D1_O);
    assign d2_first = (h2 != 4'd0) ? S_D2_H : ((t2 != 4'd0) ? S_D2_T : S_D2_O);

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign tx_valid  = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        p1_d    = p1_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
`ifdef ESCENC_DECCKM_EN
        app_d   = app_q;
`endif
        tx_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    type_d = cmd_kind;
                    p1_d   = cmd_p1;
                    val2_d = sat_add(cmd_p2, OFF9);
                    case (cmd_kind)
                        R_DA:     val1_d = DA_ID8;
                        R_DSR_OK: val1_d = 8'h00;
                        default:  val1_d = sat_add(cmd_p1, OFF9);
                    endcase
`ifdef ESCENC_DECCKM_EN
                    app_d = app_cursor;
`endif
                    case (cmd_kind)
                        R_CHAR:                     state_d = S_CHAR;
                        R_CPR, R_DSR_OK, R_DA, R_KEY: state_d = S_ESC;
                        default:                    state_d = S_IDLE;
                    endcase
                end
            end

            S_ESC: begin
                tx_data = ASCII_ESC;
                if (tx_ready) state_d = S_INTRO;
            end

            S_INTRO: begin
                tx_data = key_ss3 ? ASCII_O : ASCII_LBRACK;
                if (tx_ready) begin
                    case (type_q)
                        R_CPR:    state_d = d1_first;
                        R_DSR_OK: state_d = S_D1_O;
                        R_DA:     state_d = S_QMARK;
                        default:  state_d = S_FINAL;
                    endcase
                end
            end

            S_QMARK: begin
                tx_data = ASCII_QMARK;
                if (tx_ready) state_d = d1_first;
            end

            S_D1_H: begin
                tx_data = ascii_digit(h1);
                if (tx_ready) state_d = S_D1_T;
            end

            S_D1_T: begin
                tx_data = ascii_digit(t1);
                if (tx_ready) state_d = S_D1_O;
            end

            S_D1_O: begin
                tx_data = ascii_digit(o1);
                if (tx_ready) state_d = (type_q == R_CPR) ? S_SEP : S_FINAL;
            end

            S_SEP: begin
                tx_data = ASCII_SEMI;
                if (tx_ready) state_d = d2_first;
            end

            S_D2_H: begin
                tx_data = ascii_digit(h2);
                if (tx_ready) state_d = S_D2_T;
            end

            S_D2_T: begin
                tx_data = ascii_digit(t2);
                if (tx_ready) state_d = S_D2_O;
            end

            S_D2_O: begin
                tx_data = ascii_digit(o2);
                if (tx_ready) state_d = S_FINAL;
            end

            S_FINAL: begin
                case (type_q)
                    R_CPR:    tx_data = ASCII_R;
                    R_DSR_OK: tx_data = ASCII_N;
                    R_DA:     tx_data = ASCII_C;
                    default:  tx_data = p1_q;   // key letter, sent without range check
                endcase
                if (tx_ready) state_d = S_IDLE;
            end

            S_CHAR: begin
                tx_data = p1_q;
                if (tx_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= R_CHAR;
            p1_q    <= 8'h00;
            val1_q  <= 8'h00;
            val2_q  <= 8'h00;
`ifdef ESCENC_DECCKM_EN
            app_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            p1_q    <= p1_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
`ifdef ESCENC_DECCKM_EN
            app_q   <= app_d;
`endif
        end
    end

endmodule

// File: tb/tb_escape_encoder.sv
// -----------------------------------------------------------------------------
// tb_escape_encoder
// Drives requests into escape_encoder and compares the emitted byte stream
// against sequences built from decimal-string formatting of the parameters.
// -----------------------------------------------------------------------------
module tb_escape_encoder;

    localparam int POS_OFFSET = 1;
    localparam int DA_ID      = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_type = 3'd0;
    logic [7:0] cmd_p1 = 8'h00;
    logic [7:0] cmd_p2 = 8'h00;
    logic       app_cursor = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int last_cycles = 0;

    always #5 clk = ~clk;

    escape_encoder #(
        .POS_OFFSET (POS_OFFSET),
        .DA_ID      (DA_ID)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_p1     (cmd_p1),
        .cmd_p2     (cmd_p2),
`ifdef ESCENC_DECCKM_EN
        .app_cursor (app_cursor),
`endif
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    // Reference model: expected bytes for one request.
    task automatic push_dec(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic build_expected(input logic [2:0] t, input logic [7:0] p1,
                                  input logic [7:0] p2, input logic app);
        int v;
        bit ss3;
        exp_q.delete();
        ss3 = 1'b0;
`ifdef ESCENC_DECCKM_EN
        ss3 = app;
`else
        if (app) ss3 = 1'b0;
`endif
        case (t)
            3'd0: exp_q.push_back(p1);
            3'd1: begin
                exp_q.push_back(8'h1b); exp_q.push_back("[");
                v = int'(p1) + POS_OFFSET; if (v > 255) v = 255;
                push_dec(v);
                exp_q.push_back(";");
                v = int'(p2) + POS_OFFSET; if (v > 255) v = 255;
                push_dec(v);
                exp_q.push_back("R");
            end
            3'd2: begin
                exp_q.push_back(8'h1b); exp_q.push_back("[");
                exp_q.push_back("0"); exp_q.push_back("n");
            end
            3'd3: begin
                exp_q.push_back(8'h1b); exp_q.push_back("["); exp_q.push_back("?");
                push_dec(DA_ID);
                exp_q.push_back("c");
            end
            3'd4: begin
                exp_q.push_back(8'h1b);
                exp_q.push_back(ss3 ? 8'h4f : 8'h5b);
                exp_q.push_back(p1);
            end
            default: ;
        endcase
    endtask

    // Driver + checker for one request. mode: 0 ready always, 1 toggle, 2 random.
    // stop_after>0 returns after that many byte handshakes (used before a reset).
    // junk keeps a different request on the command port while busy.
    task automatic run_cmd(input logic [2:0] t, input logic [7:0] p1, input logic [7:0] p2,
                           input logic app, input int mode, input int stop_after,
                           input bit junk, input string tag);
        int cycles;
        int popped;
        cycles = 0;
        popped = 0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got cmd_ready=%b want 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_type = t; cmd_p1 = p1; cmd_p2 = p2; app_cursor = app;
        tx_ready = 1'b0;
        build_expected(t, p1, p2, app);
        @(negedge clk);
        if (junk) begin
            cmd_valid = 1'b1; cmd_type = 3'd0; cmd_p1 = 8'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        app_cursor = ~app;
        while (exp_q.size() != 0 && cycles < 64) begin
            if (stop_after != 0 && popped == stop_after) return;
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0] || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s byte%0d: got valid=%b data=%h ready=%b busy=%b want valid=1 data=%h ready=0 busy=1",
                         tag, popped, tx_valid, tx_data, cmd_ready, busy, exp_q[0]);
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_ready) begin
                void'(exp_q.pop_front());
                popped++;
            end
            cycles++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got %0d bytes left want 0", tag, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_idle: got valid=%b ready=%b busy=%b want 0 1 0",
                     tag, tx_valid, cmd_ready, busy);
        end
        cmd_valid = 1'b0;
        tx_ready = 1'b0;
        last_cycles = cycles;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b data=%h busy=%b want 1 0 00 0",
                     cmd_ready, tx_valid, tx_data, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cpr();
        run_cmd(3'd1, 8'd0, 8'd0, 1'b0, 0, 0, 1'b0, "cpr_0_0");
        n_checks++;
        if (last_cycles != 6) begin
            n_fail++;
            $display("FAIL cpr_0_0_cycles: got %0d want 6", last_cycles);
        end
        run_cmd(3'd1, 8'd23, 8'd254, 1'b0, 0, 0, 1'b0, "cpr_23_254");
        run_cmd(3'd1, 8'd23, 8'd255, 1'b0, 0, 0, 1'b0, "cpr_sat");
        run_cmd(3'd1, 8'd9, 8'd98, 1'b0, 2, 0, 1'b0, "cpr_9_98");
        run_cmd(3'd1, 8'd99, 8'd8, 1'b0, 2, 0, 1'b0, "cpr_99_8");
    endtask

    task automatic test_da_stall();
        run_cmd(3'd3, 8'h00, 8'h00, 1'b0, 1, 0, 1'b0, "da_toggle");
    endtask

    task automatic test_key();
        run_cmd(3'd4, 8'h41, 8'h00, 1'b1, 0, 0, 1'b0, "key_a_app1");
        run_cmd(3'd4, 8'h44, 8'h00, 1'b0, 0, 0, 1'b0, "key_d_app0");
        run_cmd(3'd4, 8'h5a, 8'h00, 1'b0, 2, 0, 1'b0, "key_verbatim");
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd0, 8'h1b, 8'h00, 1'b0, 0, 0, 1'b1, "b2b_char");
        run_cmd(3'd2, 8'h00, 8'h00, 1'b0, 0, 0, 1'b1, "b2b_dsr");
    endtask

    task automatic test_unknown();
        run_cmd(3'd5, 8'h41, 8'h42, 1'b0, 0, 0, 1'b0, "unknown5");
        run_cmd(3'd7, 8'h41, 8'h42, 1'b0, 0, 0, 1'b0, "unknown7");
    endtask

    task automatic test_reset_mid();
        run_cmd(3'd1, 8'd5, 8'd6, 1'b0, 0, 2, 1'b0, "rst_mid_cpr");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_async: got valid=%b ready=%b data=%h want 0 1 00",
                     tx_valid, cmd_ready, tx_data);
        end
        exp_q.delete();
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after: got valid=%b ready=%b want 0 1", tx_valid, cmd_ready);
        end
        tx_ready = 1'b0;
        run_cmd(3'd0, 8'h41, 8'h00, 1'b0, 0, 0, 1'b0, "rst_mid_char");
    endtask

    task automatic test_random();
        logic [2:0] t;
        logic [7:0] p1;
        for (int n = 0; n < 40; n++) begin
            t  = 3'($urandom_range(0, 7));
            p1 = (t == 3'd4 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h41, 8'h44))
                                                         : 8'($urandom);
            run_cmd(t, p1, 8'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpr();
        test_da_stall();
        test_key();
        test_back_to_back();
        test_unknown();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
